// File: rtl/camera_frame_gate.sv
// Write-side frame gate for the camera RGB FIFO: picks which frames are written, counts frames and drops.
// Optional capture watchdog enabled by defining CAMERA_FRAME_GATE_TIMEOUT_EN.
module camera_frame_gate #(
    parameter int CNT_W       = 16,
    parameter int SKIP_W      = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              CAMERA_PIXCLK,
    input  logic              reset_n,
    input  logic              pix_valid,
    input  logic              pix_sop,
    input  logic              pix_eop,
    input  logic              fifo_wrfull,
    input  logic              cfg_enable,
    input  logic              cfg_single,
    input  logic [SKIP_W-1:0] cfg_skip,
    input  logic              ovf_clear,
    output logic              wr_gate,
    output logic              capturing,
    output logic              frame_done,
    output logic              overflow_sticky,
    output logic [CNT_W-1:0]  frame_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic              timeout_sticky
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOP = 2'd1,
        ST_CAPTURE  = 2'd2,
        ST_DROP     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [SKIP_W-1:0] SKIP_ONE = {{(SKIP_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d, sop_state_s;
    logic [SKIP_W-1:0]  skip_cnt_q, skip_cnt_d, sop_skip_s;
    logic               single_pend_q, single_pend_d;
    logic               frame_done_q, overflow_q, overflow_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;
    logic               armed_s, sop_evt_s, sop_gate_s, sop_trunc_s;
    logic               wr_gate_s, trunc_s, eop_wr_s, timeout_hit_s;

    assign armed_s   = cfg_enable | single_pend_q;
    assign sop_evt_s = pix_valid & pix_sop;

    // Outcome of a frame start, shared by every state that can see a sop
    always_comb begin
        sop_state_s = ST_IDLE;
        sop_skip_s  = skip_cnt_q;
        sop_gate_s  = 1'b0;
        sop_trunc_s = 1'b0;
        if (!armed_s) begin
            sop_state_s = ST_IDLE;
        end else if (skip_cnt_q != {SKIP_W{1'b0}}) begin
            sop_state_s = ST_WAIT_SOP;
            sop_skip_s  = skip_cnt_q - SKIP_ONE;
        end else if (fifo_wrfull) begin
            sop_state_s = ST_DROP;
            sop_skip_s  = cfg_skip;
            sop_trunc_s = 1'b1;
        end else begin
            sop_state_s = ST_CAPTURE;
            sop_skip_s  = cfg_skip;
            sop_gate_s  = 1'b1;
        end
    end

    // Next-state and write-gate decode
    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        wr_gate_s  = 1'b0;
        trunc_s    = 1'b0;
        eop_wr_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (armed_s) state_d = ST_WAIT_SOP;
                else         state_d = ST_IDLE;
            end
            ST_WAIT_SOP: begin
                if (sop_evt_s) begin
                    state_d    = sop_state_s;
                    skip_cnt_d = sop_skip_s;
                    wr_gate_s  = sop_gate_s;
                    trunc_s    = sop_trunc_s;
                end else begin
                    state_d = ST_WAIT_SOP;
                end
            end
            ST_CAPTURE: begin
                // A sop without the previous eop abandons the old frame uncounted
                if (sop_evt_s) begin
                    state_d    = sop_state_s;
                    skip_cnt_d = sop_skip_s;
                    wr_gate_s  = sop_gate_s;
                    trunc_s    = sop_trunc_s;
                end else if (pix_valid && fifo_wrfull) begin
                    state_d = ST_DROP;
                    trunc_s = 1'b1;
                end else if (pix_valid && pix_eop) begin
                    wr_gate_s = 1'b1;
                    eop_wr_s  = 1'b1;
                    state_d   = (cfg_enable || cfg_single) ? ST_WAIT_SOP : ST_IDLE;
                end else if (timeout_hit_s) begin
                    state_d = armed_s ? ST_WAIT_SOP : ST_IDLE;
                end else begin
                    wr_gate_s = pix_valid;
                end
            end
            ST_DROP: begin
                if (sop_evt_s) begin
                    state_d    = sop_state_s;
                    skip_cnt_d = sop_skip_s;
                    wr_gate_s  = sop_gate_s;
                    trunc_s    = sop_trunc_s;
                end else if (pix_valid && pix_eop) begin
                    state_d = armed_s ? ST_WAIT_SOP : ST_IDLE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Counter and sticky updates; a new overflow wins over ovf_clear
    always_comb begin
        frame_cnt_d   = eop_wr_s ? (frame_cnt_q + CNT_ONE) : frame_cnt_q;
        drop_cnt_d    = (trunc_s || timeout_hit_s) ? (drop_cnt_q + CNT_ONE) : drop_cnt_q;
        overflow_d    = overflow_q;
        single_pend_d = single_pend_q;
        if (trunc_s)        overflow_d = 1'b1;
        else if (ovf_clear) overflow_d = 1'b0;
        else                overflow_d = overflow_q;
        if (cfg_single)                single_pend_d = 1'b1;
        else if (trunc_s || eop_wr_s)  single_pend_d = 1'b0;
        else                           single_pend_d = single_pend_q;
    end

    // State and status registers
    always_ff @(posedge CAMERA_PIXCLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            skip_cnt_q    <= {SKIP_W{1'b0}};
            single_pend_q <= 1'b0;
            frame_done_q  <= 1'b0;
            overflow_q    <= 1'b0;
            frame_cnt_q   <= {CNT_W{1'b0}};
            drop_cnt_q    <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            skip_cnt_q    <= skip_cnt_d;
            single_pend_q <= single_pend_d;
            frame_done_q  <= eop_wr_s;
            overflow_q    <= overflow_d;
            frame_cnt_q   <= frame_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

`ifdef CAMERA_FRAME_GATE_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] wd_q, wd_d;
    logic        timeout_q, timeout_d;

    assign timeout_hit_s = (state_q == ST_CAPTURE) && !pix_valid && (wd_q == WD_LAST);

    // Watchdog counts idle pixel cycles while capturing
    always_comb begin
        wd_d      = 16'd0;
        timeout_d = timeout_q;
        if ((state_q == ST_CAPTURE) && !pix_valid) wd_d = wd_q + 16'd1;
        else                                        wd_d = 16'd0;
        if (timeout_hit_s)  timeout_d = 1'b1;
        else if (ovf_clear) timeout_d = 1'b0;
        else                timeout_d = timeout_q;
    end

    // Watchdog registers
    always_ff @(posedge CAMERA_PIXCLK or negedge reset_n) begin
        if (!reset_n) begin
            wd_q      <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_sticky = timeout_q;
`else
    logic unused_timeout_s;
    assign unused_timeout_s = ^TIMEOUT_CYC;
    assign timeout_hit_s    = 1'b0;
    assign timeout_sticky   = 1'b0;
`endif

    assign wr_gate         = wr_gate_s;
    assign capturing       = (state_q == ST_CAPTURE);
    assign frame_done      = frame_done_q;
    assign overflow_sticky = overflow_q;
    assign frame_count     = frame_cnt_q;
    assign drop_count      = drop_cnt_q;

endmodule

// File: tb/tb_camera_frame_gate.sv
// Directed bench for camera_frame_gate: 8x2-pixel frames with hand-computed write counts and status.
module tb_camera_frame_gate;

    localparam int CNT_W  = 16;
    localparam int SKIP_W = 4;
`ifdef CAMERA_FRAME_GATE_TIMEOUT_EN
    localparam int TO_CYC = 20;
`else
    localparam int TO_CYC = 65535;
`endif

    logic              CAMERA_PIXCLK;
    logic              reset_n;
    logic              pix_valid, pix_sop, pix_eop, fifo_wrfull;
    logic              cfg_enable, cfg_single, ovf_clear;
    logic [SKIP_W-1:0] cfg_skip;
    logic              wr_gate, capturing, frame_done, overflow_sticky, timeout_sticky;
    logic [CNT_W-1:0]  frame_count, drop_count;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int fd_cnt   = 0;
    int viol     = 0;
    int w0       = 0;

    camera_frame_gate #(.CNT_W(CNT_W), .SKIP_W(SKIP_W), .TIMEOUT_CYC(TO_CYC)) dut (
        .CAMERA_PIXCLK   (CAMERA_PIXCLK),
        .reset_n         (reset_n),
        .pix_valid       (pix_valid),
        .pix_sop         (pix_sop),
        .pix_eop         (pix_eop),
        .fifo_wrfull     (fifo_wrfull),
        .cfg_enable      (cfg_enable),
        .cfg_single      (cfg_single),
        .cfg_skip        (cfg_skip),
        .ovf_clear       (ovf_clear),
        .wr_gate         (wr_gate),
        .capturing       (capturing),
        .frame_done      (frame_done),
        .overflow_sticky (overflow_sticky),
        .frame_count     (frame_count),
        .drop_count      (drop_count),
        .timeout_sticky  (timeout_sticky)
    );

    initial CAMERA_PIXCLK = 1'b0;
    always #5 CAMERA_PIXCLK = ~CAMERA_PIXCLK;

    // frame_done pulses counted away from the active edge
    always @(negedge CAMERA_PIXCLK) begin
        if (frame_done === 1'b1) fd_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // n valid pixels; optional sop on first, eop on last, full and single pulses at given index
    task automatic send_pix(input int n, input bit has_sop, input bit has_eop,
                            input int full_at, input int single_at);
        for (int p = 0; p < n; p++) begin
            @(negedge CAMERA_PIXCLK);
            pix_valid   = 1'b1;
            pix_sop     = has_sop && (p == 0);
            pix_eop     = has_eop && (p == n - 1);
            fifo_wrfull = (p == full_at);
            cfg_single  = (p == single_at);
            #1;
            if (wr_gate === 1'b1) wr_cnt++;
            if (wr_gate === 1'b1 && (fifo_wrfull || !pix_valid)) viol++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CAMERA_PIXCLK);
            pix_valid   = 1'b0;
            pix_sop     = 1'b0;
            pix_eop     = 1'b0;
            fifo_wrfull = 1'b0;
            cfg_single  = 1'b0;
            ovf_clear   = 1'b0;
            #1;
            if (wr_gate !== 1'b0) viol++;
        end
    endtask

    task automatic frame();
        send_pix(16, 1'b1, 1'b1, -1, -1);
        idle(2);
    endtask

    initial begin
        reset_n = 1'b0; pix_valid = 1'b0; pix_sop = 1'b0; pix_eop = 1'b0;
        fifo_wrfull = 1'b0; cfg_enable = 1'b0; cfg_single = 1'b0; ovf_clear = 1'b0;
        cfg_skip = 4'd0;
        repeat (3) @(negedge CAMERA_PIXCLK);
        check_eq("rst_wr_gate", 32'(wr_gate), 32'd0);
        check_eq("rst_capturing", 32'(capturing), 32'd0);
        check_eq("rst_frame_done", 32'(frame_done), 32'd0);
        check_eq("rst_overflow", 32'(overflow_sticky), 32'd0);
        check_eq("rst_frame_count", 32'(frame_count), 32'd0);
        check_eq("rst_drop_count", 32'(drop_count), 32'd0);
        check_eq("rst_timeout", 32'(timeout_sticky), 32'd0);
        reset_n = 1'b1;

        // Continuous capture of three frames
        cfg_enable = 1'b1;
        idle(2);
        wr_cnt = 0; fd_cnt = 0;
        repeat (3) frame();
        check_eq("cont_writes", 32'(wr_cnt), 32'd48);
        check_eq("cont_frame_count", 32'(frame_count), 32'd3);
        check_eq("cont_frame_done", 32'(fd_cnt), 32'd3);
        check_eq("cont_drop_count", 32'(drop_count), 32'd0);

        // Decimation: write one, skip two
        cfg_skip = 4'd2;
        for (int f = 0; f < 6; f++) begin
            w0 = wr_cnt;
            frame();
            check_eq($sformatf("skip_f%0d_writes", f + 1), 32'(wr_cnt - w0),
                     (f == 0 || f == 3) ? 32'd16 : 32'd0);
        end
        check_eq("skip_frame_count", 32'(frame_count), 32'd5);
        cfg_skip = 4'd0;

        // Overflow on pixel 5 truncates the frame, next frame is whole
        w0 = wr_cnt;
        send_pix(16, 1'b1, 1'b1, 4, -1);
        idle(2);
        check_eq("ovf_writes", 32'(wr_cnt - w0), 32'd4);
        check_eq("ovf_sticky_set", 32'(overflow_sticky), 32'd1);
        check_eq("ovf_drop_count", 32'(drop_count), 32'd1);
        w0 = wr_cnt;
        frame();
        check_eq("ovf_next_writes", 32'(wr_cnt - w0), 32'd16);
        check_eq("ovf_frame_count", 32'(frame_count), 32'd6);
        @(negedge CAMERA_PIXCLK);
        ovf_clear = 1'b1;
        idle(2);
        check_eq("ovf_sticky_clear", 32'(overflow_sticky), 32'd0);

        // Single shot armed mid-frame
        cfg_enable = 1'b0;
        idle(2);
        w0 = wr_cnt;
        send_pix(16, 1'b1, 1'b1, -1, 5);
        idle(2);
        check_eq("single_armframe_writes", 32'(wr_cnt - w0), 32'd0);
        w0 = wr_cnt;
        frame();
        check_eq("single_shot_writes", 32'(wr_cnt - w0), 32'd16);
        w0 = wr_cnt;
        frame();
        check_eq("single_after_writes", 32'(wr_cnt - w0), 32'd0);
        check_eq("single_frame_count", 32'(frame_count), 32'd7);

        // Missing eop: the new sop restarts capture
        cfg_enable = 1'b1;
        idle(2);
        w0 = wr_cnt;
        send_pix(5, 1'b1, 1'b0, -1, -1);
        check_eq("noeop_capturing", 32'(capturing), 32'd1);
        frame();
        check_eq("noeop_writes", 32'(wr_cnt - w0), 32'd21);
        check_eq("noeop_frame_count", 32'(frame_count), 32'd8);
        check_eq("noeop_drop_count", 32'(drop_count), 32'd1);

        // Reset in the middle of a captured frame
        send_pix(6, 1'b1, 1'b0, -1, -1);
        @(negedge CAMERA_PIXCLK);
        reset_n = 1'b0;
        pix_valid = 1'b1; pix_sop = 1'b0; pix_eop = 1'b0;
        #1;
        check_eq("midrst_wr_gate", 32'(wr_gate), 32'd0);
        check_eq("midrst_capturing", 32'(capturing), 32'd0);
        check_eq("midrst_frame_count", 32'(frame_count), 32'd0);
        check_eq("midrst_drop_count", 32'(drop_count), 32'd0);
        check_eq("midrst_frame_done", 32'(frame_done), 32'd0);
        @(negedge CAMERA_PIXCLK);
        reset_n = 1'b1;
        w0 = wr_cnt;
        send_pix(9, 1'b0, 1'b1, -1, -1);
        idle(2);
        check_eq("postrst_tail_writes", 32'(wr_cnt - w0), 32'd0);
        w0 = wr_cnt;
        frame();
        check_eq("postrst_writes", 32'(wr_cnt - w0), 32'd16);
        check_eq("postrst_frame_count", 32'(frame_count), 32'd1);

        // Pixel stream stalls mid-capture
        send_pix(3, 1'b1, 1'b0, -1, -1);
        idle(20);
        check_eq("stall19_timeout", 32'(timeout_sticky), 32'd0);
        check_eq("stall19_capturing", 32'(capturing), 32'd1);
        idle(1);
`ifdef CAMERA_FRAME_GATE_TIMEOUT_EN
        check_eq("stall20_timeout", 32'(timeout_sticky), 32'd1);
        check_eq("stall20_capturing", 32'(capturing), 32'd0);
        check_eq("stall20_drop_count", 32'(drop_count), 32'd1);
        @(negedge CAMERA_PIXCLK);
        ovf_clear = 1'b1;
        idle(2);
        check_eq("timeout_clear", 32'(timeout_sticky), 32'd0);
`else
        check_eq("stall20_timeout", 32'(timeout_sticky), 32'd0);
        check_eq("stall20_capturing", 32'(capturing), 32'd1);
        check_eq("stall20_drop_count", 32'(drop_count), 32'd0);
`endif

        check_eq("wr_gate_legal", 32'(viol), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/camera_frame_gate.md
Name: camera_frame_gate

Overview:
- Write-side capture controller for the camera RGB path.
- Sits between the Bayer-to-RGB converter (pixel valid, sop, eop) and the dual-clock RGB FIFO write port; all logic is in the CAMERA_PIXCLK domain.
- Decides which frames enter the FIFO: enable/disable, single-shot, frame decimation and overflow recovery. Only frames starting on a clean sop are written.
- Provides frame/drop counters and sticky status for software.

Parameters:
- CNT_W, 16, width of frame_count and drop_count.
- SKIP_W, 4, width of cfg_skip.
- TIMEOUT_CYC, 65535, pixclk cycles without pix_valid before a CAPTURE timeout (optional feature only).

Ports:
- CAMERA_PIXCLK  in  1  pixel clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pix_valid  in  1  RGB pixel valid and inside active area.
- pix_sop  in  1  pixel is (0,0); qualified by pix_valid.
- pix_eop  in  1  pixel is (W-1,H-1); qualified by pix_valid.
- fifo_wrfull  in  1  FIFO write-side full.
- cfg_enable  in  1  level; continuous capture when 1.
- cfg_single  in  1  one-cycle pulse; arms capture of exactly one frame.
- cfg_skip  in  SKIP_W  write 1 frame, then skip cfg_skip frames.
- ovf_clear  in  1  one-cycle pulse; clears overflow_sticky.
- wr_gate  out  1  combinational; this cycle's pixel is to be written.
- capturing  out  1  state is CAPTURE.
- frame_done  out  1  one-cycle pulse, registered, after a complete frame is written.
- overflow_sticky  out  1  set when a capture frame is truncated by FIFO full.
- frame_count  out  CNT_W  complete frames written; wraps.
- drop_count  out  CNT_W  frames truncated by overflow; wraps.
- timeout_sticky  out  1  see Optional Feature.

Behaviour:
Reset:
- state = IDLE, skip_cnt = 0, single_pend = 0.
- All outputs 0: frame_done, capturing, overflow_sticky, timeout_sticky, both counters; wr_gate = 0 because state is IDLE.

Arming:
- cfg_single sets single_pend. single_pend clears when that frame's eop is written or when it is truncated.
- armed = cfg_enable | single_pend.

States:
- IDLE: go to WAIT_SOP when armed.
- WAIT_SOP, on pix_valid & pix_sop:
  - armed and skip_cnt == 0 and ~fifo_wrfull: write the sop pixel; go to CAPTURE; skip_cnt <= cfg_skip.
  - armed and skip_cnt == 0 and fifo_wrfull: no write; go to DROP; drop_count +1; overflow_sticky = 1; skip_cnt <= cfg_skip.
  - armed and skip_cnt != 0: skip_cnt -1; stay in WAIT_SOP (the frame is skipped).
  - not armed: go to IDLE.
- CAPTURE:
  - wr_gate = pix_valid & ~fifo_wrfull.
  - pix_valid & fifo_wrfull: no write; go to DROP; drop_count +1; overflow_sticky = 1.
  - eop written: frame_count +1; frame_done pulse next cycle; go to WAIT_SOP if still armed after single_pend update, otherwise IDLE.
  - pix_valid & pix_sop (missing eop): treat as a new frame start; count no frame; apply the WAIT_SOP sop rules this same cycle.
- DROP:
  - wr_gate = 0.
  - Exit to WAIT_SOP (or IDLE if not armed) on pix_valid & pix_eop, or on pix_valid & pix_sop. A sop exit applies the WAIT_SOP rules that cycle.

Enable changes:
- cfg_enable deasserted mid-CAPTURE: the current frame completes; disarming takes effect at frame end. It never truncates a frame.

Other rules:
- ovf_clear has priority below a simultaneous new overflow, i.e. the sticky remains set.
- wr_gate is never 1 when fifo_wrfull = 1 or pix_valid = 0.
- Counters wrap modulo 2^CNT_W.
- Asserting reset mid-frame returns to IDLE immediately. The next write is the sop of a later frame.

Optional Feature:
Macro: CAMERA_FRAME_GATE_TIMEOUT_EN
- Defined:
  - A 16-bit watchdog counts cycles in CAPTURE with pix_valid = 0, resetting on pix_valid.
  - On reaching TIMEOUT_CYC, state goes to WAIT_SOP (or IDLE), timeout_sticky = 1, and drop_count +1.
  - timeout_sticky is cleared by ovf_clear.
- Undefined: no watchdog logic; timeout_sticky tied 0.

Test Plan:
- Reset, cfg_enable = 1, cfg_skip = 0, fifo never full, 3 frames of 8x2 pixels -> 48 wr_gate pulses, frame_count = 3, 3 frame_done pulses, drop_count = 0.
- cfg_skip = 2, 6 frames -> only frames 1 and 4 are written; frame_count = 2; wr_gate = 0 throughout frames 2, 3, 5, 6.
- fifo_wrfull high on pixel 5 of frame 1 -> wr_gate = 0 from pixel 5 to frame end; overflow_sticky = 1, drop_count = 1; frame 2 is fully written (16 writes); ovf_clear -> sticky = 0.
- cfg_enable = 0, cfg_single pulse mid-frame -> the rest of that frame is ignored, the next full frame is written, the frame after is not; frame_count = 1.
- Sop arrives in CAPTURE without a prior eop -> the old frame is not counted and the new frame is written from its sop. Reset asserted mid-CAPTURE -> all outputs 0 and no writes until the next sop after re-enable.
- With CAMERA_FRAME_GATE_TIMEOUT_EN, TIMEOUT_CYC = 20: pix_valid held low 20 cycles in CAPTURE -> timeout_sticky = 1, drop_count +1, state WAIT_SOP. Without the macro: timeout_sticky stays 0.
